td4_exec_regs: RTL
==================

Name: td4_exec_regs

Overview:
- Decode, operand-select and write-back stage of the TD4 4-bit CPU.
- Decodes the 8-bit instruction word fetched at its own program counter.
- Drives the adder operand (A, B, IN or zero) and the immediate into the 4-bit ripple adder built from full-adder cells.
- Consumes the adder's sum and carry-out the same cycle; writes back into A, B, OUT or PC, and latches the carry flag.

Parameters:
- RESET_PC, 4'h0, program counter value loaded on reset.
- RESET_OUT, 4'h0, output-port register value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  execute enable; 1 = retire one instruction this edge, 0 = hold all state (single-step / halt).
- instr  input  8  instruction from program ROM at address pc; [7:4] opcode, [3:0] immediate.
- in_port  input  4  external input switches, sampled combinationally for IN instructions.
- sum  input  4  adder sum of alu_op + imm (from the external ripple adder).
- cout  input  1  adder carry-out.
- pc  output  4  program counter, ROM address.
- alu_op  output  4  selected adder operand (combinational).
- imm  output  4  immediate passed to adder, equal to instr[3:0] (combinational).
- reg_a  output  4  register A.
- reg_b  output  4  register B.
- out_port  output  4  output-port register.
- carry  output  1  carry flag.

Behaviour:
- Reset (rst=1 at edge, priority over en):
  - pc=RESET_PC, reg_a=0, reg_b=0, out_port=RESET_OUT, carry=0.
  - Reset mid-program discards the current instruction; no partial write.
- Operand select (combinational), sel = {op[1], op[0]|op[3]}:
  - 00 -> reg_a.
  - 01 -> reg_b.
  - 10 -> in_port.
  - 11 -> 4'h0.
- Destination decode on op[3:2]:
  - 00 -> A.
  - 01 -> B.
  - 10 -> OUT.
  - 11 -> PC, and only if jump_take = op[0] | ~carry.
  - All 16 opcodes are therefore defined; no illegal-opcode trap.
- Retire (en=1, rst=0), exactly one instruction per edge, zero extra latency:
  - Destination register <= sum. No other data register changes.
  - carry <= cout on every retired instruction, including OUT and jumps. JMP/JNC add 0+imm, so they clear carry.
  - pc <= sum if jump taken, else pc+1 mod 16 (15 wraps to 0, no flag).
  - JNC tests carry as latched by the previous instruction, never the current cout.
- Hold (en=0): all registers hold; combinational outputs still track instr/in_port.
- Width rules: all datapaths are 4 bits; sum overflow appears only via cout; no saturation.
- Reference ISA mapping:
  - 0000 ADD A,Im; 0101 ADD B,Im; 0011 MOV A,Im; 0111 MOV B,Im.
  - 0001 MOV A,B; 0100 MOV B,A; 0010 IN A; 0110 IN B.
  - 1001 OUT B; 1011 OUT Im; 1111 JMP Im; 1110 JNC Im.
- No combinational loop: sum depends on alu_op/imm, which depend only on registers and inputs.

Decomposition:
- Package td4_pkg:
  - Opcode constants for the twelve ISA instructions.
  - Operand-select encodings SEL_A/SEL_B/SEL_IN/SEL_ZERO.
  - Destination encodings DST_A/DST_B/DST_OUT/DST_PC.
- Sub-module td4_decode (combinational):
  - Inputs: opcode, carry.
  - Outputs: sel[1:0], ld_a, ld_b, ld_out, ld_pc.
  - Outputs are one-hot-or-zero; ld_pc is already qualified by jump_take.
- td4_exec_regs holds the state registers, operand mux and PC incrementer.

Test Plan:
- All tests use a bench model of the adder: sum/cout = alu_op + imm.
- Reset: rst=1 for 2 cycles with en=1 -> pc=0, reg_a=reg_b=out_port=0, carry=0. Repeat with rst asserted mid-program -> same values next edge.
- Arithmetic and carry:
  - MOV A,9 (0x39) -> reg_a=9, carry=0.
  - Then ADD A,8 (0x08) -> reg_a=1, carry=1, pc advanced by 2.
- Conditional jump: after carry=1, JNC 5 (0xE5) -> pc=prev+1, not taken, carry becomes 0. A second JNC 5 -> pc=5.
- Transfers and I/O:
  - in_port=0xA, IN B (0x60) -> reg_b=0xA.
  - MOV A,B (0x10) -> reg_a=0xA.
  - OUT B (0x90) -> out_port=0xA.
  - OUT Im 3 (0xB3) -> out_port=3.
- PC wrap and JMP:
  - Run NOP-equivalent ADD A,0 from pc=14 -> pc goes 15 then 0.
  - JMP 0xC (0xFC) -> pc=0xC, carry=0.
- Enable hold: en=0 for 5 cycles with instr=0x3F -> no state change. Raise en -> reg_a=0xF after one edge.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared constants for the TD4 4-bit CPU: ISA opcodes, operand-select and
// destination encodings used by the decoder and the execute/register stage.
package td4_pkg;

  localparam int DATA_W = 4;

  // Reference ISA opcodes (instr[7:4])
  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_JNC_IM   = 4'b1110;
  localparam logic [3:0] OP_JMP_IM   = 4'b1111;

  // Adder operand select, sel = {op[1], op[0] | op[3]}
  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  // Write-back destination, op[3:2]
  localparam logic [1:0] DST_A   = 2'b00;
  localparam logic [1:0] DST_B   = 2'b01;
  localparam logic [1:0] DST_OUT = 2'b10;
  localparam logic [1:0] DST_PC  = 2'b11;

  // Sequential program counter advance; wraps 15 -> 0 silently
  function automatic logic [DATA_W-1:0] pc_incr(input logic [DATA_W-1:0] pc);
    return pc + 4'd1;
  endfunction

endpackage

// File: rtl/td4_exec_regs_if.sv
// Bus between the TD4 execute/register stage and its surroundings:
// program ROM, input switches, output port and the external ripple adder.
interface td4_exec_regs_if;
  import td4_pkg::*;

  logic              en;
  logic [7:0]        instr;
  logic [DATA_W-1:0] in_port;
  logic [DATA_W-1:0] sum;
  logic              cout;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] alu_op;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] out_port;
  logic              carry;

  // Environment side: supplies ROM data, switches, enable and adder result
  modport master (
    output en, instr, in_port, sum, cout,
    input  pc, alu_op, imm, reg_a, reg_b, out_port, carry
  );

  // CPU execute stage side
  modport slave (
    input  en, instr, in_port, sum, cout,
    output pc, alu_op, imm, reg_a, reg_b, out_port, carry
  );

endinterface

// File: rtl/td4_decode.sv
// Combinational TD4 instruction decoder: operand select plus one-hot-or-zero
// register load strobes. The PC load is already gated by the jump condition.
module td4_decode
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry,
  output logic [1:0] sel,
  output logic       ld_a,
  output logic       ld_b,
  output logic       ld_out,
  output logic       ld_pc
);

  // Operand select and destination strobes from the opcode bits
  always_comb begin
    sel    = {opcode[1], opcode[0] | opcode[3]};
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    ld_out = 1'b0;
    ld_pc  = 1'b0;
    case (opcode[3:2])
      DST_A:   ld_a   = 1'b1;
      DST_B:   ld_b   = 1'b1;
      DST_OUT: ld_out = 1'b1;
      // JMP (op[0]=1) always taken; JNC only when the latched carry is clear
      DST_PC:  ld_pc  = opcode[0] | ~carry;
      default: ;
    endcase
  end

endmodule

// File: rtl/td4_exec_regs.sv
// TD4 decode / operand-select / write-back stage. Selects the adder operand,
// takes the external adder's sum and carry back the same cycle and retires
// one instruction per enabled clock edge.
module td4_exec_regs
  import td4_pkg::*;
#(
  parameter logic [3:0] RESET_PC  = 4'h0,
  parameter logic [3:0] RESET_OUT = 4'h0
)(
  input  logic          clk,
  input  logic          rst,
  td4_exec_regs_if.slave bus
);

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] out_q;
  logic              carry_q;
  logic [DATA_W-1:0] operand;
  logic [1:0]        sel;
  logic              ld_a;
  logic              ld_b;
  logic              ld_out;
  logic              ld_pc;

  td4_decode u_decode (
    .opcode (bus.instr[7:4]),
    .carry  (carry_q),
    .sel    (sel),
    .ld_a   (ld_a),
    .ld_b   (ld_b),
    .ld_out (ld_out),
    .ld_pc  (ld_pc)
  );

  // Adder operand mux; depends only on registers and inputs, never on sum
  always_comb begin
    operand = '0;
    case (sel)
      SEL_A:    operand = a_q;
      SEL_B:    operand = b_q;
      SEL_IN:   operand = bus.in_port;
      SEL_ZERO: operand = '0;
      default:  operand = '0;
    endcase
  end

  // Architectural state: reset wins, otherwise retire one instruction when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= RESET_OUT;
      carry_q <= 1'b0;
    end else if (bus.en) begin
      if (ld_a)   a_q   <= bus.sum;
      if (ld_b)   b_q   <= bus.sum;
      if (ld_out) out_q <= bus.sum;
      pc_q    <= ld_pc ? bus.sum : pc_incr(pc_q);
      carry_q <= bus.cout;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.alu_op   = operand;
  assign bus.imm      = bus.instr[3:0];
  assign bus.reg_a    = a_q;
  assign bus.reg_b    = b_q;
  assign bus.out_port = out_q;
  assign bus.carry    = carry_q;

endmodule
